fb_pixel_serializer: RTL

Downstream consumer of the render core's framebuffer AXI Stream output, after the DMA stream engine. Unpacks each CMD_STREAM_WIDTH-bit framebuffer beat into 16-bit RGB565 pixels. Emits them as a pixel stream with start-of-frame and end-of-line markers for the display controller. Tracks x/y position, checks frame alignment against input tlast, and flags mismatches.

---
 rtl/fb_pixel_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fb_pixel_serializer.sv
// Unpacks framebuffer stream beats into RGB565 pixels with start-of-frame and
// end-of-line markers, tracking x/y position and checking tlast alignment.
module fb_pixel_serializer #(
    parameter int STREAM_WIDTH      = 16,
    parameter int LINE_WIDTH_PIXELS = 320,
    parameter int LINE_COUNT        = 240
) (
    input  logic                    aclk,
    input  logic                    resetn,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
    output logic                    m_pixel_tvalid,
    input  logic                    m_pixel_tready,
    output logic [15:0]             m_pixel_tdata,
    output logic                    m_pixel_tuser,
    output logic                    m_pixel_tlast,
    output logic                    frame_done,
    output logic                    err_sync
);

    localparam int PPW    = STREAM_WIDTH / 16;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int X_W    = (LINE_WIDTH_PIXELS > 1) ? $clog2(LINE_WIDTH_PIXELS) : 1;
    localparam int Y_W    = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PPW - 1);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(LINE_WIDTH_PIXELS - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(LINE_COUNT - 1);

    generate
        if (!(STREAM_WIDTH == 16 || STREAM_WIDTH == 32 || STREAM_WIDTH == 64 ||
              STREAM_WIDTH == 128 || STREAM_WIDTH == 256) ||
            LINE_WIDTH_PIXELS < 1 || LINE_COUNT < 1 ||
            ((LINE_WIDTH_PIXELS * LINE_COUNT) % PPW) != 0) begin : g_bad_params
            $error("fb_pixel_serializer: illegal parameter combination");
        end
    endgenerate

    logic [STREAM_WIDTH-1:0] r_hold_data;
    logic                    r_hold_last;
    logic                    r_hold_valid;
    logic [LANE_W-1:0]       r_lane;
    logic [X_W-1:0]          r_x;
    logic [Y_W-1:0]          r_y;
    logic                    r_frame_done;
    logic                    r_err_sync;

    logic        w_pix_hs;
    logic        w_beat_end;
    logic        w_accept;
    logic        w_x_last;
    logic        w_y_last;
    logic        w_frame_last;
    logic [15:0] w_pixel;

    assign w_pix_hs     = r_hold_valid & m_pixel_tready;
    assign w_beat_end   = w_pix_hs & (r_lane == LANE_LAST);
    assign w_x_last     = (r_x == X_LAST);
    assign w_y_last     = (r_y == Y_LAST);
    assign w_frame_last = w_x_last & w_y_last;

    // A beat may be accepted in the same cycle its last lane drains, so a
    // continuous input stream produces pixels with no bubbles.
    assign s_axis_tready = ~r_hold_valid | w_beat_end;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    generate
        if (PPW == 1) begin : g_single_lane
            assign w_pixel = r_hold_data[15:0];
        end else begin : g_multi_lane
            assign w_pixel = r_hold_data[r_lane*16 +: 16];
        end
    endgenerate

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_hold_data  <= '0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_lane       <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
            r_err_sync   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side sees pre-edge values regardless of statement order.
            r_frame_done <= 1'b0;

            if (w_accept) begin
                r_hold_data  <= s_axis_tdata;
                r_hold_last  <= s_axis_tlast;
                r_hold_valid <= 1'b1;
                r_lane       <= '0;
            end else if (w_beat_end) begin
                r_hold_valid <= 1'b0;
                r_lane       <= '0;
            end else if (w_pix_hs) begin
                r_lane <= r_lane + 1'b1;
            end

            if (w_pix_hs) begin
                if (w_beat_end && r_hold_last && !w_frame_last) begin
                    // Early tlast: resynchronise to the upstream frame boundary.
                    r_err_sync   <= 1'b1;
                    r_x          <= '0;
                    r_y          <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_x <= w_x_last ? '0 : r_x + 1'b1;
                    if (w_x_last) begin
                        r_y <= w_y_last ? '0 : r_y + 1'b1;
                    end
                    if (w_frame_last) begin
                        r_frame_done <= 1'b1;
                        if (w_beat_end && !r_hold_last) begin
                            r_err_sync <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign m_pixel_tvalid = r_hold_valid;
    assign m_pixel_tdata  = w_pixel;
    assign m_pixel_tuser  = r_hold_valid & (r_x == '0) & (r_y == '0);
    assign m_pixel_tlast  = r_hold_valid & w_x_last;
    assign frame_done     = r_frame_done;
    assign err_sync       = r_err_sync;

endmodule
